// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the memory, and the arbiter.
// Handshake: a requester raises *_req with stable operands and holds both until its one-cycle *_done
// pulse; the arbiter holds mem_req and the mem_* command steady until mem_ack (valid with mem_rdata)
// or timeout; err_o and rdata_o qualify a done pulse and hold their values between transactions.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              f_done;
  logic              d_done;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy_o;
  logic [1:0]        state_dbg;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output f_done, d_done, rdata_o, err_o, mem_req, mem_we, mem_addr, mem_wdata, busy_o, state_dbg
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  f_done, d_done, rdata_o, err_o, mem_req, mem_we, mem_addr, mem_wdata, busy_o, state_dbg
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter onto a single memory port,
// one outstanding transaction at a time, with a bounded wait for mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              resetl,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_data;

  // Data wins if it is alone, or if both ask and fetch owned the last completed grant.
  assign grant_data = bus.d_req && (!bus.f_req || (last_q == OWN_FETCH));

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_FETCH;
      last_q  <= OWN_DATA;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.f_req || bus.d_req) begin
          state_d = BUSY;
          cnt_d   = '0;
          owner_d = grant_data;
          if (grant_data) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.f_addr;
            wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // An ack in the expiry cycle is checked first so it completes normally.
        if (bus.mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          last_d  = owner_q;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.f_done    = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign bus.d_done    = (state_q == DONE) && (owner_q == OWN_DATA);
  assign bus.err_o     = err_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for alternation, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic CLK;
  logic resetl;
  int   checks;
  int   errors;
  logic [DW-1:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          is_data;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_delay;
    logic [DW-1:0] mem_rdata;
    logic          exp_we;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.f_req     = 1'b0;
    bus.f_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [DW-1:0] exp_r;
    if (v.is_data) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.f_req   = 1'b1;
      bus.f_addr  = v.addr;
      bus.d_we    = 1'b1;
      bus.d_wdata = 64'hFFFF_0000_FFFF_0000;
    end
    bus.mem_ack = 1'b0;
    exp_q.push_back(v.exp_rdata);
    @(negedge CLK);
    for (int c = 0; c <= v.ack_delay; c++) begin
      check({tag, "_mem_req"}, 64'(bus.mem_req), 64'd1);
      check({tag, "_mem_addr"}, bus.mem_addr, v.addr);
      check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(v.exp_we));
      check({tag, "_mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      if (c == v.ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.mem_rdata;
      end else begin
        bus.mem_rdata = {$urandom, $urandom};
      end
      @(negedge CLK);
    end
    bus.mem_ack = 1'b0;
    exp_r = exp_q.pop_front();
    check({tag, "_f_done"}, 64'(bus.f_done), 64'(!v.is_data));
    check({tag, "_d_done"}, 64'(bus.d_done), 64'(v.is_data));
    check({tag, "_err_o"}, 64'(bus.err_o), 64'd0);
    check({tag, "_rdata_o"}, bus.rdata_o, exp_r);
    check({tag, "_done_mem_req"}, 64'(bus.mem_req), 64'd0);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge CLK);
    check({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_idle_done"}, 64'({bus.f_done, bus.d_done}), 64'd0);
  endtask

  initial begin
    int   n;
    int   last_cyc;
    int   busy_cnt;
    logic seen;
    vec_t tail;

    checks = 0;
    errors = 0;
    idle_inputs();

    //                    data  we   addr                    wdata                   ack rdata                   ewe  ewdata                  erdata
    vecs[0] = '{1'b0, 1'b0, 64'h40,                  64'h0,                  0,  64'hDEAD,               1'b0, 64'h0,                  64'hDEAD};
    vecs[1] = '{1'b1, 1'b1, 64'h100,                 64'h55,                 3,  64'hBEEF,               1'b1, 64'h55,                 64'hDEAD};
    vecs[2] = '{1'b1, 1'b0, 64'h200,                 64'h99,                 1,  64'h1234_5678_9ABC_DEF0, 1'b0, 64'h99,                 64'h1234_5678_9ABC_DEF0};
    vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                  2,  64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 64'h0,                  64'hA5A5_A5A5_5A5A_5A5A};
    vecs[4] = '{1'b1, 1'b1, 64'h8,                   64'hFFFF_FFFF_FFFF_FFFF, 0,  64'h77,                 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_5A5A_5A5A};
    vecs[5] = '{1'b0, 1'b0, 64'h3000,                64'h0,                  14, 64'hCAFE,               1'b0, 64'h0,                  64'hCAFE};
    vecs[6] = '{1'b1, 1'b0, 64'h0,                   64'h0,                  13, 64'h0123,               1'b0, 64'h0,                  64'h0123};

    // reset values
    resetl = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    check("rst_done", 64'({bus.f_done, bus.d_done}), 64'd0);
    check("rst_err_o", 64'(bus.err_o), 64'd0);
    check("rst_rdata_o", bus.rdata_o, 64'd0);
    check("rst_busy_o", 64'(bus.busy_o), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'd0);
    resetl = 1'b0;

    // both requesters held: fetch, data, fetch, data, one done every 3 cycles
    bus.f_req     = 1'b1;
    bus.f_addr    = 64'h1000;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 64'h2000;
    bus.d_wdata   = 64'h0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h11;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge CLK);
      if (bus.mem_req && exp_q.size() > 0)
        check("alt_mem_addr", bus.mem_addr, (exp_q[0] != '0) ? 64'h2000 : 64'h1000);
      if (bus.f_done || bus.d_done) begin
        check("alt_both_done", 64'(bus.f_done && bus.d_done), 64'd0);
        check("alt_owner", 64'(bus.d_done), exp_q.pop_front());
        if (n > 0) check("alt_spacing", 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        n++;
        if (n == 4) begin
          bus.f_req = 1'b0;
          bus.d_req = 1'b0;
          break;
        end
      end
    end
    check("alt_count", 64'(n), 64'd4);
    exp_q.delete();
    bus.mem_ack = 1'b0;
    @(negedge CLK);
    check("alt_idle_busy", 64'(bus.busy_o), 64'd0);

    // vector table
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // no ack at all: 15 BUSY cycles, then d_done with err
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h500;
    bus.mem_ack = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLK);
      if (bus.mem_req) busy_cnt++;
      if (bus.f_done || bus.d_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_done_seen", 64'(seen), 64'd1);
    check("to_busy_cycles", 64'(busy_cnt), 64'd15);
    check("to_d_done", 64'(bus.d_done), 64'd1);
    check("to_f_done", 64'(bus.f_done), 64'd0);
    check("to_err_o", 64'(bus.err_o), 64'd1);
    check("to_rdata_o", bus.rdata_o, 64'h0123);
    bus.d_req = 1'b0;
    @(negedge CLK);
    check("to_idle_state", 64'(bus.state_dbg), 64'd0);
    check("to_err_hold", 64'(bus.err_o), 64'd1);

    // normal completion clears the error flag
    tail = '{1'b0, 1'b0, 64'h44, 64'h0, 0, 64'h9, 1'b0, 64'h0, 64'h9};
    run_txn(tail, "post_to");

    // reset while BUSY aborts without a done; the held request restarts afterwards
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h600;
    bus.d_wdata = 64'h66;
    repeat (2) @(negedge CLK);
    check("mr_busy_before", 64'(bus.mem_req), 64'd1);
    resetl = 1'b1;
    @(negedge CLK);
    check("mr_mem_req", 64'(bus.mem_req), 64'd0);
    check("mr_done", 64'({bus.f_done, bus.d_done}), 64'd0);
    check("mr_mem_addr", bus.mem_addr, 64'd0);
    check("mr_mem_we", 64'(bus.mem_we), 64'd0);
    check("mr_mem_wdata", bus.mem_wdata, 64'd0);
    check("mr_rdata_o", bus.rdata_o, 64'd0);
    check("mr_err_o", 64'(bus.err_o), 64'd0);
    check("mr_busy_o", 64'(bus.busy_o), 64'd0);
    resetl = 1'b0;
    @(negedge CLK);
    check("mr_rearb_req", 64'(bus.mem_req), 64'd1);
    check("mr_rearb_addr", bus.mem_addr, 64'h600);
    check("mr_rearb_wdata", bus.mem_wdata, 64'h66);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 64'hABCD;
    @(negedge CLK);
    bus.mem_ack = 1'b0;
    check("mr_d_done", 64'(bus.d_done), 64'd1);
    check("mr_wr_rdata", bus.rdata_o, 64'd0);
    bus.d_req = 1'b0;
    @(negedge CLK);
    check("mr_final_idle", 64'(bus.busy_o), 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max BUSY cycles awaiting mem_ack (range 1-255).
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port resetl  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port f_req  input  1  fetch requester read request.
REQ-007 SHALL have port f_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port d_req  input  1  data requester request.
REQ-009 SHALL have port d_we  input  1  data request is write (1) / read (0).
REQ-010 SHALL have port d_addr  input  ADDR_W  data address.
REQ-011 SHALL have port d_wdata  input  DATA_W  data write value.
REQ-012 SHALL have port f_done, d_done  output  1 each  one-cycle completion pulse per requester.
REQ-013 SHALL have port rdata_o  output  DATA_W  registered read data for the completed read.
REQ-014 SHALL have port err_o  output  1  qualifies done pulse: transaction timed out.
REQ-015 SHALL have port mem_req  output  1  memory access strobe.
REQ-016 SHALL have port mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  registered memory command.
REQ-017 SHALL have port mem_ack  input  1  memory completion; mem_rdata  input  DATA_W  valid with mem_ack.
REQ-018 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-020 IDLE: if any req high at edge, SHALL latch winner's addr/we/wdata into mem_* regs, record owner, go BUSY; else stay.
REQ-021 Arbitration SHALL be round-robin: single requester wins; both requesting -> the one not owning the last completed grant wins.
REQ-022 Fetch commands SHALL drive mem_we=0 and mem_wdata=0.
REQ-023 BUSY: mem_req SHALL be 1 every cycle; mem_* command SHALL stay constant.
REQ-024 BUSY with mem_ack=1 SHALL go DONE; rdata_o captures mem_rdata only if command was read; err flag cleared.
REQ-025 BUSY wait counter SHALL start at 0 on entry, increment each BUSY cycle without mem_ack; when count reaches TIMEOUT-1 without ack, go DONE with err set, rdata_o unchanged.
REQ-026 mem_ack in the same cycle as timeout expiry SHALL win (normal completion, err_o=0).
REQ-027 DONE: exactly owner's done output =1 for that single cycle, err_o=err flag, mem_req=0; next state IDLE unconditionally.
REQ-028 Requests SHALL NOT be sampled in BUSY or DONE; requesters hold req and operands stable until their done pulse.
REQ-029 A req still high in the cycle after done SHALL be treated as a new request (back-to-back allowed).
REQ-030 Latency: req sampled edge k, mem_ack in first BUSY cycle -> done high in cycle k+2; minimum 3 cycles per transaction.
REQ-031 Last-grant pointer SHALL update on entry to DONE (both normal and timeout).
REQ-032 mem_ack outside BUSY SHALL be ignored.
REQ-033 rdata_o and err_o SHALL hold values between transactions; err_o valid only when a done is high.

Reset
REQ-034 resetl=1 at edge SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, f_done=d_done=0, err_o=0, rdata_o=0, counter=0, busy_o=0.
REQ-035 Reset SHALL set last grant = data, so first simultaneous request goes to fetch.
REQ-036 Reset mid-transaction SHALL abort with no done pulse; pending req re-arbitrated after resetl falls.

Verification
REQ-037 Fetch read: f_req=1, f_addr=0x40, mem_ack next cycle, mem_rdata=0xDEAD -> mem_addr=0x40, mem_we=0, f_done pulse at k+2, rdata_o=0xDEAD, err_o=0.
REQ-038 Simultaneous requests after reset, both held -> fetch served first, data second, then fetch; grants alternate, never two consecutive to one requester while both pending.
REQ-039 Data write d_we=1, d_addr=0x100, d_wdata=0x55, ack after 3 BUSY cycles -> mem_we=1, mem_wdata=0x55 stable during BUSY, d_done once, rdata_o unchanged.
REQ-040 No mem_ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then d_done with err_o=1, IDLE next cycle.
REQ-041 mem_ack on final timeout cycle -> err_o=0, rdata_o=mem_rdata.
REQ-042 resetl=1 during BUSY -> next cycle mem_req=0, no done pulse, outputs at reset values.
